eth_mdio_responder: RTL and testbench
=====================================

ETH_MDIO_RESPONDER -- requirements
Module: eth_mdio_responder

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
 PHY_ADDR  5'd1  MDIO address this responder answers to
 PHY_ID1  16'h0007  read-only value of register 2
 PHY_ID2  16'hC0F1  read-only value of register 3
REQ-002 SHALL have ports, one per line: name  direction  width  meaning:
 clk  in  1  sole clock (>= 8x MDC frequency)
 rstn  in  1  reset, asynchronous, active-low
 mdc  in  1  management clock from initiator, asynchronous to clk
 i_mdio  in  1  MDIO pad input (IOBUF O)
 o_mdio  out  1  MDIO pad drive value (IOBUF I)
 t_mdio  out  1  1 = release pad (IOBUF T)
 lw_en  in  1  local register write strobe
 lw_addr  in  5  local write address
 lw_data  in  16  local write data
 lr_addr  in  5  local read address
 lr_data  out  16  local read data, registered
 wr_valid  out  1  one-clk pulse: MDIO write committed
 wr_addr  out  5  address of committed MDIO write
 wr_data  out  16  data of committed MDIO write
REQ-003 SHALL use one clock, clk; reset rstn is asynchronous and active-low.

Function
REQ-004 SHALL synchronise mdc and i_mdio through two flops each, then detect MDC rising and falling edges on clk.
REQ-005 SHALL sample MDIO on detected MDC rising edge; SHALL change o_mdio/t_mdio only on detected MDC falling edge.
REQ-006 SHALL implement states IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA; bits MSB first.
REQ-007 IDLE: saturating count of consecutive 1s; a 0 with count >= 32 -> ST; a 0 with count < 32 clears count.
REQ-008 ST: next bit 1 -> OP; 0 -> IDLE, count cleared.
REQ-009 OP: 2'b01 write, 2'b10 read; 00/11 -> IDLE, count cleared.
REQ-010 PHYAD (5 bits), REGAD (5 bits); PHYAD != PHY_ADDR -> IDLE after the 5th bit, pad never driven.
REQ-011 Write: TA 2 bits ignored, WDATA 16 bits; after 16th bit, register updated and wr_valid pulses exactly one clk with wr_addr/wr_data.
REQ-012 Read: first TA bit t_mdio=1; on falling edge before second TA bit t_mdio=0, o_mdio=0; then 16 data bits each launched on a falling edge; on falling edge after last bit t_mdio=1; -> IDLE.
REQ-013 Register file 32x16; reg 2 and 3 return PHY_ID1/PHY_ID2, writes to them discarded (wr_valid still pulses).
REQ-014 Read data SHALL be latched at end of REGAD; a write landing later does not alter the in-flight read.
REQ-015 lr_data SHALL equal register[lr_addr] one clk after lr_addr.
REQ-016 lw_en and MDIO commit on same clk, same address: MDIO value wins; different addresses: both apply.
REQ-017 After any frame end or abort, preamble count restarts at 0.

Reset
REQ-018 rstn low SHALL force: state IDLE, count 0, t_mdio=1, o_mdio=1, wr_valid=0, wr_addr=0, wr_data=0, lr_data=0, all writable registers 0.
REQ-019 rstn asserted mid-read SHALL release the pad within the same clk (asynchronous).

Configuration
REQ-020 Macro MDIO_PREAMBLE_SUPPRESS_EN defined: after one completed addressed frame, a single 1 bit suffices as preamble for the next frame; undefined: 32 ones always required.

Structure
REQ-021 Shared package eth_pkg SHALL hold mdio_op_t (OP_WRITE=2'b01, OP_READ=2'b10), MDIO_PREAMBLE_LEN=32, responder state enum.
REQ-022 Sub-module mdio_sync SHALL contain the two-flop synchronisers and MDC edge detection.

Verification
REQ-023 32 ones, write PHYAD=1 REGAD=4 data 16'hA5C3 -> wr_valid one clk, wr_addr=4, wr_data=16'hA5C3; lr_addr=4 -> lr_data=16'hA5C3.
REQ-024 Then read REGAD=4 -> t_mdio=1 first TA, 0 second TA, bits 1010010111000011 returned, t_mdio=1 afterward.
REQ-025 Read REGAD=2 -> 16'h0007; write 16'hFFFF to reg 3 then read -> 16'hC0F1.
REQ-026 31-one preamble, or PHYAD=5, or OP=2'b11 -> t_mdio stays 1, no wr_valid.
REQ-027 rstn low at RDATA bit 8 -> t_mdio=1 immediately; after release a full 32-one frame reads reg 4 as 0.
REQ-028 With MDIO_PREAMBLE_SUPPRESS_EN: back-to-back read with 1-bit preamble answered; without: ignored.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared MDIO definitions: opcodes, preamble length, responder FSM states.
package eth_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10
  } mdio_op_t;

  localparam int MDIO_PREAMBLE_LEN = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_WDATA,
    S_RDATA
  } mdio_state_t;

  // Registers 2 and 3 hold the PHY identifier and ignore writes.
  function automatic logic is_id_reg(input logic [4:0] addr);
    return (addr == 5'd2) || (addr == 5'd3);
  endfunction

endpackage

// File: rtl/mdio_sync.sv
// Brings MDC and MDIO into the clk domain and flags MDC edges.
// mdio_bit has the same two-flop latency as the MDC edge flags, so a bit
// sampled on mdc_rise is the pad value at the MDC rising edge.
module mdio_sync (
  input  logic clk,
  input  logic rstn,
  input  logic mdc,
  input  logic mdio_pad,
  output logic mdc_rise,
  output logic mdc_fall,
  output logic mdio_bit
);

  logic [2:0] mdc_q;
  logic [1:0] mdio_q;

  // Two synchroniser stages plus one history stage for MDC edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mdc_q  <= 3'b000;
      mdio_q <= 2'b11;
    end else begin
      mdc_q  <= {mdc_q[1:0], mdc};
      mdio_q <= {mdio_q[0], mdio_pad};
    end
  end

  assign mdc_rise = mdc_q[1] & ~mdc_q[2];
  assign mdc_fall = ~mdc_q[1] & mdc_q[2];
  assign mdio_bit = mdio_q[1];

endmodule

// File: rtl/eth_mdio_responder.sv
// MDIO (clause 22) responder with a 32x16 register file.
// Build option MDIO_PREAMBLE_SUPPRESS_EN: once an addressed frame has
// completed, a single preamble 1 is enough to start the next frame.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | counting preamble ones, waiting for the first start bit
// S_ST    | expecting the second start bit (1)
// S_OP    | collecting the 2-bit opcode
// S_PHYAD | collecting PHY address, abort if not ours
// S_REGAD | collecting register address, read word latched at the end
// S_TA    | turnaround; for reads the pad is taken before the 2nd bit
// S_WDATA | collecting 16 write bits, commit after the last one
// S_RDATA | shifting out 16 read bits, pad released on the next fall
module eth_mdio_responder
  import eth_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0007,
  parameter logic [15:0] PHY_ID2  = 16'hC0F1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mdc,
  input  logic        i_mdio,
  output logic        o_mdio,
  output logic        t_mdio,
  input  logic        lw_en,
  input  logic [4:0]  lw_addr,
  input  logic [15:0] lw_data,
  input  logic [4:0]  lr_addr,
  output logic [15:0] lr_data,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data
);

  localparam logic [5:0] PRE_LEN = 6'(MDIO_PREAMBLE_LEN);

  logic        mdc_rise, mdc_fall, mdio_bit;
  mdio_state_t state, state_nx;
  logic [5:0]  pre_cnt, pre_cnt_nx;
  logic [4:0]  bit_cnt, bit_cnt_nx;
  logic        is_read, is_read_nx;
  logic [4:0]  phyad, phyad_nx;
  logic [4:0]  regad, regad_nx;
  logic [15:0] sh, sh_nx;
  logic        t_nx, o_nx;
  logic        commit, frame_done, frame_abort, short_pre;
  logic [15:0] wbits, rd_word, lr_word;
  logic [4:0]  reg_sel;
  logic [15:0] regs [32];

  mdio_sync u_sync (
    .clk      (clk),
    .rstn     (rstn),
    .mdc      (mdc),
    .mdio_pad (i_mdio),
    .mdc_rise (mdc_rise),
    .mdc_fall (mdc_fall),
    .mdio_bit (mdio_bit)
  );

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  logic pre_ok;

  // Remember that the initiator has completed a frame with us; any abort
  // drops back to requiring a full preamble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            pre_ok <= 1'b0;
    else if (frame_done)  pre_ok <= 1'b1;
    else if (frame_abort) pre_ok <= 1'b0;
  end

  assign short_pre = pre_ok && (pre_cnt != 6'd0);
`else
  logic unused_frame_flags;
  assign unused_frame_flags = frame_done ^ frame_abort;
  assign short_pre = 1'b0;
`endif

  assign wbits   = {sh[14:0], mdio_bit};
  assign reg_sel = {regad[3:0], mdio_bit};

  // Register file read ports: the ID registers are constants.
  always_comb begin
    rd_word = regs[reg_sel];
    if (reg_sel == 5'd2)      rd_word = PHY_ID1;
    else if (reg_sel == 5'd3) rd_word = PHY_ID2;
    lr_word = regs[lr_addr];
    if (lr_addr == 5'd2)      lr_word = PHY_ID1;
    else if (lr_addr == 5'd3) lr_word = PHY_ID2;
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      pre_cnt <= '0;
      bit_cnt <= '0;
      is_read <= 1'b0;
      phyad   <= '0;
      regad   <= '0;
      sh      <= '0;
      t_mdio  <= 1'b1;
      o_mdio  <= 1'b1;
    end else begin
      state   <= state_nx;
      pre_cnt <= pre_cnt_nx;
      bit_cnt <= bit_cnt_nx;
      is_read <= is_read_nx;
      phyad   <= phyad_nx;
      regad   <= regad_nx;
      sh      <= sh_nx;
      t_mdio  <= t_nx;
      o_mdio  <= o_nx;
    end
  end

  // Next-state logic: bits are taken on MDC rise, the pad moves on MDC fall.
  always_comb begin
    state_nx    = state;
    pre_cnt_nx  = pre_cnt;
    bit_cnt_nx  = bit_cnt;
    is_read_nx  = is_read;
    phyad_nx    = phyad;
    regad_nx    = regad;
    sh_nx       = sh;
    t_nx        = t_mdio;
    o_nx        = o_mdio;
    commit      = 1'b0;
    frame_done  = 1'b0;
    frame_abort = 1'b0;
    if (mdc_rise) begin
      case (state)
        S_IDLE: begin
          if (mdio_bit) begin
            if (pre_cnt < PRE_LEN) pre_cnt_nx = pre_cnt + 6'd1;
          end else begin
            pre_cnt_nx = '0;
            if (pre_cnt >= PRE_LEN || short_pre) state_nx = S_ST;
          end
        end
        S_ST: begin
          bit_cnt_nx = '0;
          if (mdio_bit) begin
            state_nx = S_OP;
          end else begin
            state_nx    = S_IDLE;
            frame_abort = 1'b1;
          end
        end
        S_OP: begin
          sh_nx = wbits;
          if (bit_cnt == 5'd0) begin
            bit_cnt_nx = 5'd1;
          end else begin
            bit_cnt_nx = '0;
            if (wbits[1:0] == OP_WRITE) begin
              is_read_nx = 1'b0;
              state_nx   = S_PHYAD;
            end else if (wbits[1:0] == OP_READ) begin
              is_read_nx = 1'b1;
              state_nx   = S_PHYAD;
            end else begin
              state_nx    = S_IDLE;
              frame_abort = 1'b1;
            end
          end
        end
        S_PHYAD: begin
          phyad_nx = {phyad[3:0], mdio_bit};
          if (bit_cnt == 5'd4) begin
            bit_cnt_nx = '0;
            if (phyad_nx == PHY_ADDR) begin
              state_nx = S_REGAD;
            end else begin
              state_nx    = S_IDLE;
              frame_abort = 1'b1;
            end
          end else begin
            bit_cnt_nx = bit_cnt + 5'd1;
          end
        end
        S_REGAD: begin
          regad_nx = reg_sel;
          if (bit_cnt == 5'd4) begin
            bit_cnt_nx = '0;
            state_nx   = S_TA;
            sh_nx      = rd_word;
          end else begin
            bit_cnt_nx = bit_cnt + 5'd1;
          end
        end
        S_TA: begin
          if (bit_cnt == 5'd1) begin
            bit_cnt_nx = '0;
            state_nx   = is_read ? S_RDATA : S_WDATA;
          end else begin
            bit_cnt_nx = 5'd1;
          end
        end
        S_WDATA: begin
          sh_nx = wbits;
          if (bit_cnt == 5'd15) begin
            bit_cnt_nx = '0;
            commit     = 1'b1;
            frame_done = 1'b1;
            state_nx   = S_IDLE;
            pre_cnt_nx = '0;
          end else begin
            bit_cnt_nx = bit_cnt + 5'd1;
          end
        end
        S_RDATA: begin
          if (bit_cnt < 5'd16) bit_cnt_nx = bit_cnt + 5'd1;
        end
        default: state_nx = S_IDLE;
      endcase
    end else if (mdc_fall) begin
      if (state == S_TA && is_read && bit_cnt == 5'd1) begin
        t_nx = 1'b0;
        o_nx = 1'b0;
      end else if (state == S_RDATA) begin
        if (bit_cnt < 5'd16) begin
          t_nx  = 1'b0;
          o_nx  = sh[15];
          sh_nx = {sh[14:0], 1'b0};
        end else begin
          t_nx       = 1'b1;
          o_nx       = 1'b1;
          bit_cnt_nx = '0;
          pre_cnt_nx = '0;
          frame_done = 1'b1;
          state_nx   = S_IDLE;
        end
      end
    end
  end

  // Register file; an MDIO commit overrides a local write to the same address.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (lw_en && !is_id_reg(lw_addr)) regs[lw_addr] <= lw_data;
      if (commit && !is_id_reg(regad))  regs[regad]   <= wbits;
    end
  end

  // Commit notification and registered local read port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      lr_data  <= '0;
    end else begin
      wr_valid <= commit;
      if (commit) begin
        wr_addr <= regad;
        wr_data <= wbits;
      end
      lr_data <= lr_word;
    end
  end

endmodule

// File: tb/tb_eth_mdio_responder.sv
// Scoreboard bench for eth_mdio_responder: stimulus pushes expected MDIO
// writes/reads into queues, monitors pop them when the DUT responds.
module tb_eth_mdio_responder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mdc = 1'b1;
  logic        tb_drive = 1'b1;
  logic        i_mdio;
  logic        o_mdio, t_mdio;
  logic        lw_en = 1'b0;
  logic [4:0]  lw_addr = '0;
  logic [15:0] lw_data = '0;
  logic [4:0]  lr_addr = '0;
  logic [15:0] lr_data;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  int n_vec  = 0;
  int n_miss = 0;
  bit abort_expected = 1'b0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [15:0] data;
  } wr_exp_t;

  wr_exp_t     wr_q[$];
  logic [15:0] rd_q[$];

  // Open-drain style pad: initiator value when released, DUT value otherwise.
  assign i_mdio = t_mdio ? tb_drive : o_mdio;

  always #5 clk = ~clk;

  eth_mdio_responder dut (
    .clk      (clk),
    .rstn     (rstn),
    .mdc      (mdc),
    .i_mdio   (i_mdio),
    .o_mdio   (o_mdio),
    .t_mdio   (t_mdio),
    .lw_en    (lw_en),
    .lw_addr  (lw_addr),
    .lw_data  (lw_data),
    .lr_addr  (lr_addr),
    .lr_data  (lr_data),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [15:0] d);
    wr_exp_t e;
    e.addr = a;
    e.data = d;
    wr_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    mdc = 1'b0;
    tb_drive = b;
    #80;
    mdc = 1'b1;
    #80;
  endtask

  // One frame. Reads release the pad for TA + 16 data bits, then one idle 1
  // so the DUT sees the falling edge that releases the pad.
  // rst_bit >= 0 pulses rstn during that read data bit and ends the frame.
  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [15:0] wd, input bit ans,
                       input int rst_bit);
    repeat (pre) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(op[1]);
    send_bit(op[0]);
    for (int i = 4; i >= 0; i--) send_bit(phy[i]);
    for (int i = 4; i >= 0; i--) send_bit(ra[i]);
    if (op == 2'b10) begin
      mdc = 1'b0; tb_drive = 1'b1; #80;
      check("ta1_released", t_mdio, 1);
      mdc = 1'b1; #80;
      mdc = 1'b0; #80;
      check("ta2_drive", t_mdio, ans ? 32'd0 : 32'd1);
      mdc = 1'b1; #80;
      for (int i = 0; i < 16; i++) begin
        mdc = 1'b0;
        if (i == rst_bit) begin
          #39;
          check("pre_rst_drive", t_mdio, 0);
          #1 rstn = 1'b0;
          #1;
          check("rst_release_t", t_mdio, 1);
          check("rst_release_o", o_mdio, 1);
          #39 mdc = 1'b1;
          #80 rstn = 1'b1;
          return;
        end
        #80;
        mdc = 1'b1;
        #80;
      end
      send_bit(1'b1);
    end else begin
      send_bit(1'b1);
      send_bit(1'b0);
      for (int i = 15; i >= 0; i--) send_bit(wd[i]);
    end
  endtask

  task automatic lr_check(input string name, input logic [4:0] a, input logic [15:0] exp);
    lr_addr = a;
    @(posedge clk);
    #1;
    check(name, lr_data, exp);
  endtask

  // Write monitor: every wr_valid must match the oldest expected write and
  // last exactly one clock.
  initial begin
    wr_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (wr_valid === 1'b1) begin
        if (wr_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_wr: got addr %0h data %0h, expected no write", wr_addr, wr_data);
        end else begin
          e = wr_q.pop_front();
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
        end
        @(posedge clk);
        #1;
        check("wr_pulse_width", wr_valid, 0);
      end
    end
  end

  // Read monitor: the DUT taking the pad starts a read response.
  initial begin
    logic [15:0] got;
    logic [15:0] exp;
    forever begin
      @(negedge t_mdio);
      if (abort_expected) begin
        abort_expected = 1'b0;
        continue;
      end
      #1;
      check("ta2_level", o_mdio, 0);
      if (rd_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_drive: got t_mdio 0, expected pad released");
        continue;
      end
      exp = rd_q.pop_front();
      got = '0;
      @(posedge mdc);
      for (int i = 0; i < 16; i++) begin
        @(posedge mdc);
        got = {got[14:0], i_mdio};
      end
      check("rd_data", got, exp);
      @(posedge mdc);
      #1;
      check("rd_release", t_mdio, 1);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, expected finish by 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    #23;
    check("rst_t_mdio", t_mdio, 1);
    check("rst_o_mdio", o_mdio, 1);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_lr_data", lr_data, 0);
    #57 rstn = 1'b1;
    #80;
    send_bit(1'b0);

    // Frames that must be ignored: short preamble, wrong PHY, bad opcode.
    frame(31, 2'b01, 5'd1, 5'd9, 16'h1234, 1'b0, -1);
    frame(32, 2'b10, 5'd5, 5'd4, 16'h0000, 1'b0, -1);
    frame(32, 2'b11, 5'd1, 5'd4, 16'hA5C3, 1'b0, -1);
    lr_check("lr_reg9_untouched", 5'd9, 16'h0000);

    push_wr(5'd4, 16'hA5C3);
    frame(32, 2'b01, 5'd1, 5'd4, 16'hA5C3, 1'b1, -1);
    repeat (20) @(posedge clk);
    lr_check("lr_reg4", 5'd4, 16'hA5C3);

    rd_q.push_back(16'hA5C3);
    frame(32, 2'b10, 5'd1, 5'd4, 16'h0000, 1'b1, -1);
    rd_q.push_back(16'h0007);
    frame(32, 2'b10, 5'd1, 5'd2, 16'h0000, 1'b1, -1);
    push_wr(5'd3, 16'hFFFF);
    frame(32, 2'b01, 5'd1, 5'd3, 16'hFFFF, 1'b1, -1);
    rd_q.push_back(16'hC0F1);
    frame(32, 2'b10, 5'd1, 5'd3, 16'h0000, 1'b1, -1);

    // Back-to-back read: the idle 1 after the previous read is the only preamble.
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    rd_q.push_back(16'hA5C3);
    frame(0, 2'b10, 5'd1, 5'd4, 16'h0000, 1'b1, -1);
`else
    frame(0, 2'b10, 5'd1, 5'd4, 16'h0000, 1'b0, -1);
`endif

    // Local write port, including a discarded write to an ID register.
    @(posedge clk);
    #1;
    lw_en = 1'b1; lw_addr = 5'd5; lw_data = 16'h1234;
    @(posedge clk);
    #1;
    lw_addr = 5'd2; lw_data = 16'hBEEF;
    @(posedge clk);
    #1;
    lw_en = 1'b0;
    lr_check("lr_local_wr", 5'd5, 16'h1234);
    lr_check("lr_id_protect", 5'd2, 16'h0007);

    // Local write held on the same address through the MDIO commit clock.
    lw_en = 1'b1; lw_addr = 5'd6; lw_data = 16'h1111;
    push_wr(5'd6, 16'h2222);
    seen = 1'b0;
    fork
      frame(32, 2'b01, 5'd1, 5'd6, 16'h2222, 1'b1, -1);
      begin
        repeat (20000) begin
          @(posedge clk);
          #1;
          if (wr_valid === 1'b1) begin
            seen = 1'b1;
            break;
          end
        end
        lw_en = 1'b0;
        check("collision_commit_seen", seen, 1);
      end
    join
    lr_check("lr_collision", 5'd6, 16'h2222);

    // Reset during read data bit 8, then a fresh read sees the cleared reg 4.
    abort_expected = 1'b1;
    frame(32, 2'b10, 5'd1, 5'd4, 16'h0000, 1'b1, 8);
    #1;
    check("post_rst_wr_addr", wr_addr, 0);
    check("post_rst_wr_data", wr_data, 0);
    rd_q.push_back(16'h0000);
    frame(32, 2'b10, 5'd1, 5'd4, 16'h0000, 1'b1, -1);
    lr_check("lr_reg6_cleared", 5'd6, 16'h0000);

    #2000;
    check("rd_q_drained", rd_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
